seven_seg_scan_driver: RTL and testbench

//  Time-multiplexed 7-segment display driver downstream of the binary-to-BCD converter.
//  - Accepts a packed BCD word plus per-digit decimal points over a valid/ready handshake.
//  - Scans one common-cathode digit at a time, with dead-time blanking, PWM dimming and

---
 rtl/seven_seg_scan_driver_if.sv | 23 ++
 rtl/seven_seg_scan_driver.sv | 136 +++++++++++++
 tb/tb_seven_seg_scan_driver.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/seven_seg_scan_driver_if.sv
// rtl/seven_seg_scan_driver_if.sv - BCD word handshake between the converter and the scan driver
interface seven_seg_scan_driver_if #(
    parameter int NUM_DIGITS = 3
);
    logic [4*NUM_DIGITS-1:0] bcd_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    bcd_valid;
    logic                    bcd_ready;

    modport master (
        output bcd_in,
        output dp_in,
        output bcd_valid,
        input  bcd_ready
    );

    modport slave (
        input  bcd_in,
        input  dp_in,
        input  bcd_valid,
        output bcd_ready
    );
endinterface

// File: rtl/seven_seg_scan_driver.sv
// rtl/seven_seg_scan_driver.sv - time-multiplexed common-cathode 7-segment scan driver
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS   = 3,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seven_seg_scan_driver_if.slave bus,
    input  logic                  i_lzb_en,
    input  logic [3:0]            i_brightness,
    output logic [6:0]            o_seg_out,
    output logic                  o_dp_out,
    output logic [NUM_DIGITS-1:0] o_digit_en,
    output logic                  o_frame_done
);
    localparam int SW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [SW-1:0] SLOT_LAST  = SW'(REFRESH_DIV - 1);
    localparam logic [SW-1:0] BLANK_END  = SW'(BLANK_CYCLES);
    // PWM phase restarts on the last blank cycle so every lit window starts at pwm 0
    localparam logic [SW-1:0] PWM_SYNC   = SW'(BLANK_CYCLES - 1);
    localparam logic [DW-1:0] DIGIT_LAST = DW'(NUM_DIGITS - 1);

    logic [SW-1:0]           r_slot_cnt;
    logic [DW-1:0]           r_digit_idx;
    logic [3:0]              r_pwm_cnt;
    logic [4*NUM_DIGITS-1:0] r_disp_bcd;
    logic [NUM_DIGITS-1:0]   r_disp_dp;
    logic [4*NUM_DIGITS-1:0] r_pend_bcd;
    logic [NUM_DIGITS-1:0]   r_pend_dp;
    logic                    r_pend_full;

    logic                    w_slot_wrap;
    logic                    w_frame_end;
    logic                    w_accept;
    logic [3:0]              w_cur_bcd;
    logic                    w_cur_dp;
    logic                    w_cur_lzb;
    logic                    w_zero_run;
    logic                    w_lit;

    assign bus.bcd_ready = !r_pend_full;
    assign w_accept      = bus.bcd_valid && !r_pend_full;
    assign w_slot_wrap   = (r_slot_cnt == SLOT_LAST);
    assign w_frame_end   = w_slot_wrap && (r_digit_idx == DIGIT_LAST);

    function automatic logic [6:0] seg_lut(input logic [3:0] v);
        case (v)
            4'h0: seg_lut = 7'h3F;
            4'h1: seg_lut = 7'h06;
            4'h2: seg_lut = 7'h5B;
            4'h3: seg_lut = 7'h4F;
            4'h4: seg_lut = 7'h66;
            4'h5: seg_lut = 7'h6D;
            4'h6: seg_lut = 7'h7D;
            4'h7: seg_lut = 7'h07;
            4'h8: seg_lut = 7'h7F;
            4'h9: seg_lut = 7'h6F;
            4'hA: seg_lut = 7'h77;
            4'hB: seg_lut = 7'h7C;
            4'hC: seg_lut = 7'h39;
            4'hD: seg_lut = 7'h5E;
            4'hE: seg_lut = 7'h79;
            default: seg_lut = 7'h71;
        endcase
    endfunction

    // Pick the scanned digit and decide leading-zero blanking from digits 0..digit_idx
    always_comb begin
        w_cur_bcd  = 4'd0;
        w_cur_dp   = 1'b0;
        w_cur_lzb  = 1'b0;
        w_zero_run = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_zero_run = w_zero_run && (r_disp_bcd[4*(NUM_DIGITS-1-i) +: 4] == 4'd0);
            if (DW'(i) == r_digit_idx) begin
                w_cur_bcd = r_disp_bcd[4*(NUM_DIGITS-1-i) +: 4];
                w_cur_dp  = r_disp_dp[i];
                w_cur_lzb = i_lzb_en && w_zero_run && (i < NUM_DIGITS - 1);
            end
        end
    end

    assign w_lit = (r_slot_cnt >= BLANK_END) && !w_cur_lzb &&
                   ((i_brightness == 4'hF) || (r_pwm_cnt < i_brightness));

    // Slot, digit and PWM counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot_cnt  <= '0;
            r_digit_idx <= '0;
            r_pwm_cnt   <= 4'd0;
        end else begin
            r_slot_cnt <= w_slot_wrap ? '0 : r_slot_cnt + SW'(1);
            if (w_slot_wrap) begin
                r_digit_idx <= (r_digit_idx == DIGIT_LAST) ? '0 : r_digit_idx + DW'(1);
            end
            r_pwm_cnt <= (r_slot_cnt == PWM_SYNC) ? 4'd0 : r_pwm_cnt + 4'd1;
        end
    end

    // Input handshake into the pending buffer; pending moves to display only at frame end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_bcd  <= '0;
            r_pend_dp   <= '0;
            r_pend_full <= 1'b0;
            r_disp_bcd  <= '0;
            r_disp_dp   <= '0;
        end else if (w_frame_end && r_pend_full) begin
            r_disp_bcd  <= r_pend_bcd;
            r_disp_dp   <= r_pend_dp;
            r_pend_full <= 1'b0;
        end else if (w_accept) begin
            r_pend_bcd  <= bus.bcd_in;
            r_pend_dp   <= bus.dp_in;
            r_pend_full <= 1'b1;
        end
    end

    // Registered display outputs derived from this cycle's counter state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_seg_out    <= 7'd0;
            o_dp_out     <= 1'b0;
            o_digit_en   <= '0;
            o_frame_done <= 1'b0;
        end else begin
            o_seg_out    <= w_lit ? seg_lut(w_cur_bcd) : 7'd0;
            o_dp_out     <= w_lit && w_cur_dp;
            o_digit_en   <= w_lit ? (NUM_DIGITS'(1) << r_digit_idx) : '0;
            o_frame_done <= w_frame_end;
        end
    end
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb/tb_seven_seg_scan_driver.sv - self-checking bench for seven_seg_scan_driver
module tb_seven_seg_scan_driver;
    localparam int ND    = 3;
    localparam int RD    = 32;
    localparam int BC    = 4;
    localparam int FRAME = ND * RD;

    logic        clk;
    logic        rst_n;
    logic        lzb_en;
    logic [3:0]  brightness;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic [2:0]  digit_en;
    logic        frame_done;

    seven_seg_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

    seven_seg_scan_driver #(
        .NUM_DIGITS(ND),
        .REFRESH_DIV(RD),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .i_lzb_en(lzb_en),
        .i_brightness(brightness),
        .o_seg_out(seg_out),
        .o_dp_out(dp_out),
        .o_digit_en(digit_en),
        .o_frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    // reference model state
    int          m_cyc;
    logic [3:0]  m_disp [ND];
    logic        m_dp   [ND];
    logic [14:0] m_pend;
    logic        m_full;
    logic [14:0] src_q [$];
    logic [6:0]  lut [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    function automatic logic [12:0] observed();
        return {bus.bcd_ready, frame_done, digit_en, dp_out, seg_out};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < ND; i++) begin
            m_disp[i] = 4'd0;
            m_dp[i]   = 1'b0;
        end
        m_pend = '0;
        m_full = 1'b0;
        m_cyc  = 0;
        src_q.delete();
    endtask

    task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, m_cyc, obs, exp);
        end
    endtask

    // one clock: drive source, predict outputs from the frame arithmetic, compare
    task automatic cycle(input string tag);
        logic [14:0] head;
        logic [6:0]  e_seg;
        logic        e_dp;
        logic [2:0]  e_de;
        int          slot, dig, pwm;
        bit          lb, on, acc, bnd;
        if (src_q.size() > 0) begin
            head          = src_q[0];
            bus.bcd_valid = 1'b1;
            bus.bcd_in    = head[11:0];
            bus.dp_in     = head[14:12];
        end else begin
            head          = '0;
            bus.bcd_valid = 1'b0;
            bus.bcd_in    = 12'($urandom);
            bus.dp_in     = 3'($urandom);
        end
        slot = m_cyc % RD;
        dig  = (m_cyc / RD) % ND;
        pwm  = (slot - BC) % 16;
        lb   = 0;
        if (lzb_en && dig < ND - 1) begin
            lb = 1;
            for (int i = 0; i <= dig; i++) if (m_disp[i] != 4'd0) lb = 0;
        end
        on    = (slot >= BC) && !lb && (brightness == 4'd15 || pwm < int'(brightness));
        e_seg = on ? lut[m_disp[dig]] : 7'd0;
        e_dp  = on && m_dp[dig];
        e_de  = on ? (3'b001 << dig) : 3'b000;
        acc   = bus.bcd_valid && !m_full;
        bnd   = (m_cyc % FRAME) == FRAME - 1;
        @(posedge clk);
        #1;
        if (bnd && m_full) begin
            for (int i = 0; i < ND; i++) begin
                m_disp[i] = m_pend[4*(ND-1-i) +: 4];
                m_dp[i]   = m_pend[12+i];
            end
            m_full = 1'b0;
        end
        if (acc) begin
            m_pend = head;
            m_full = 1'b1;
            void'(src_q.pop_front());
        end
        m_cyc++;
        check(tag, observed(), {!m_full, bnd, e_de, e_dp, e_seg});
    endtask

    task automatic run(input string tag, input int n);
        for (int k = 0; k < n; k++) cycle(tag);
    endtask

    // asynchronous reset asserted mid-cycle; outputs must clear without a clock edge
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check(tag, observed(), 13'h1000);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check(tag, observed(), 13'h1000);
        end
        model_clear();
        rst_n = 1'b1;
    endtask

    task automatic push(input logic [11:0] w, input logic [2:0] d);
        src_q.push_back({d, w});
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rst_n         = 1'b1;
        lzb_en        = 1'b0;
        brightness    = 4'd15;
        bus.bcd_valid = 1'b0;
        bus.bcd_in    = '0;
        bus.dp_in     = '0;
        model_clear();
        #3;

        // reset and one plain frame of 000
        do_reset("reset");
        run("frame0", FRAME + 4);

        // 0x255 with dp on digit 1
        push(12'h255, 3'b010);
        run("load255", 2 * FRAME);

        // leading-zero blanking
        lzb_en = 1'b1;
        push(12'h007, 3'b000);
        run("lzb007", 2 * FRAME);
        push(12'h000, 3'b000);
        run("lzb000", 2 * FRAME);
        push(12'h090, 3'b001);
        run("lzb090", 2 * FRAME);
        lzb_en = 1'b0;

        // back-to-back words mid-frame, second must wait for the boundary
        run("align", 40);
        push(12'h123, 3'b100);
        push(12'h456, 3'b001);
        run("b2b", 3 * FRAME);

        // dimming
        brightness = 4'd4;
        run("bright4", FRAME);
        brightness = 4'd0;
        run("bright0", FRAME);
        brightness = 4'd15;

        // randomized words, brightness and lzb changes
        for (int k = 0; k < 10 * FRAME; k++) begin
            if ($urandom_range(0, 39) == 0 && src_q.size() < 3) begin
                push(12'($urandom), 3'($urandom));
                if ($urandom_range(0, 2) == 0) push({4'd0, 4'($urandom_range(0, 1)), 4'($urandom)}, 3'($urandom));
            end
            if ($urandom_range(0, 49) == 0)
                brightness = ($urandom_range(0, 2) == 0) ? 4'd15 : 4'($urandom);
            if ($urandom_range(0, 99) == 0) lzb_en = ~lzb_en;
            cycle("random");
        end

        // mid-slot reset with a word pending
        brightness = 4'd15;
        lzb_en     = 1'b0;
        run("drain", 4 * FRAME);
        for (int k = 0; k < FRAME && (m_cyc % FRAME) != 40; k++) cycle("seek");
        push(12'h987, 3'b111);
        run("pend", 5);
        do_reset("midreset");
        run("postreset", FRAME + 8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
